// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Request/response bundle for the shift_sequencer block.
//   master : drives start, instruction, rt_data and rs_data; observes
//            busy, done, result and illegal.
//   slave  : the sequencer itself (the reverse direction of master).
// ---------------------------------------------------------------------------
interface shift_sequencer_if;
    logic        start;
    logic [31:0] instruction;
    logic [31:0] rt_data;
    logic [31:0] rs_data;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal;

    modport master (
        output start, instruction, rt_data, rs_data,
        input  busy, done, result, illegal
    );

    modport slave (
        input  start, instruction, rt_data, rs_data,
        output busy, done, result, illegal
    );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Runs one R-type shift (sll/srl/sra/sllv/srlv/srav) one bit per clock.
//   A legal request in IDLE captures the operand, the amount and the shift
//   kind. Each SHIFT cycle moves the register one bit. A one-cycle DONE
//   then presents the final value. A non-shift instruction is refused with
//   a one-cycle illegal pulse.
//
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : shift_sequencer_if.slave
//              start, instruction[31:0], rt_data[31:0], rs_data[31:0] in;
//              busy, done, result[31:0], illegal out.
// ---------------------------------------------------------------------------
module shift_sequencer (
    input logic              clk,
    input logic              rst_n,
    shift_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] sreg_q, sreg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        arith_q, arith_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    // Instruction decode
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        legal;
    logic [4:0]  amount;

    // Register-number fields and upper rs_data bits play no part in a shift.
    logic        unused_bits;
    assign unused_bits = ^{bus.instruction[25:11], bus.rs_data[31:5]};

    assign opcode = bus.instruction[31:26];
    assign funct  = bus.instruction[5:0];

    always_comb begin
        legal = 1'b0;
        if (opcode == 6'b000000) begin
            case (funct)
                6'b000000, 6'b000010, 6'b000011,
                6'b000100, 6'b000110, 6'b000111: legal = 1'b1;
                default:                         legal = 1'b0;
            endcase
        end
    end

    // funct[2] selects the variable (register) amount forms.
    assign amount = funct[2] ? bus.rs_data[4:0] : bus.instruction[10:6];

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        arith_d   = arith_q;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (legal) begin
                        sreg_d  = bus.rt_data;
                        cnt_d   = amount;
                        left_d  = (funct[1:0] == 2'b00);
                        arith_d = (funct[1:0] == 2'b11);
                        state_d = (amount != 5'd0) ? SHIFT : DONE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                // Arithmetic fill re-uses the current bit 31, which never
                // changes during a right shift, so the captured sign persists.
                if (left_q) begin
                    sreg_d = {sreg_q[30:0], 1'b0};
                end else begin
                    sreg_d = {(arith_q & sreg_q[31]), sreg_q[31:1]};
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d == SHIFT) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= 32'h0000_0000;
            cnt_q     <= 5'd0;
            left_q    <= 1'b0;
            arith_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            arith_q   <= arith_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.result  = sreg_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//   Directed bench for shift_sequencer. A table of legal shift operations
//   with hand-computed results and latencies is run in a loop. Hand-written
//   sequences then cover the reset state, refused instructions, start held
//   across two back-to-back operations and reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic clk;
    logic rst_n;

    shift_sequencer_if bus ();

    shift_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rt;
        logic [31:0] rs;
        logic [31:0] exp_res;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, then track busy/done until done or a bound expires.
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        bit seen;
        bit busy_ok;
        bus.instruction = v.instr;
        bus.rt_data     = v.rt;
        bus.rs_data     = v.rs;
        bus.start       = 1'b1;
        step();
        // Drop start and scramble operands: the captured values must rule.
        bus.start       = 1'b0;
        bus.instruction = 32'hFFFF_FFFF;
        bus.rt_data     = ~v.rt;
        bus.rs_data     = ~v.rs;
        seen    = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                step();
            end
        end
        check($sformatf("op%0d latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("op%0d result", idx), bus.result, v.exp_res);
        check($sformatf("op%0d busy during op", idx), {31'd0, busy_ok}, 32'd1);
        step();
        check($sformatf("op%0d done width", idx), {31'd0, bus.done}, 32'd0);
        check($sformatf("op%0d busy after", idx), {31'd0, bus.busy}, 32'd0);
        check($sformatf("op%0d result held", idx), bus.result, v.exp_res);
    endtask

    task automatic run_illegal(input logic [31:0] instr, input string name);
        logic [31:0] prev;
        prev            = bus.result;
        bus.instruction = instr;
        bus.rt_data     = 32'hA5A5_A5A5;
        bus.rs_data     = 32'h0000_0003;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        check({name, " illegal pulse"}, {31'd0, bus.illegal}, 32'd1);
        check({name, " busy"}, {31'd0, bus.busy}, 32'd0);
        check({name, " result unchanged"}, bus.result, prev);
        step();
        check({name, " illegal one cycle"}, {31'd0, bus.illegal}, 32'd0);
        check({name, " busy after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    logic [31:0] exp_done_b2b [6];
    logic [31:0] exp_busy_b2b [6];

    initial begin
        //            instr          rt             rs             result         latency
        vecs[0] = '{32'h0000_0100, 32'h0000_000F, 32'h0000_0000, 32'h0000_00F0, 5};  // sll 4
        vecs[1] = '{32'h0000_07C3, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32}; // sra 31
        vecs[2] = '{32'h0000_07C2, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32}; // srl 31
        vecs[3] = '{32'h0000_0006, 32'h8000_0000, 32'hFFFF_FFE3, 32'h1000_0000, 4};  // srlv 3
        vecs[4] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};  // sll 0
        vecs[5] = '{32'h0000_0144, 32'h0000_00FF, 32'h0000_0008, 32'h0000_FF00, 9};  // sllv 8, shamt ignored
        vecs[6] = '{32'h0000_0007, 32'hF000_0000, 32'h0000_0004, 32'hFF00_0000, 5};  // srav 4
        vecs[7] = '{32'h0000_0043, 32'h7FFF_FFFE, 32'h0000_0000, 32'h3FFF_FFFF, 2};  // sra 1, positive
        vecs[8] = '{32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_0020, 32'hDEAD_BEEF, 1};  // srav, rs low bits 0

        // Cycles 1..6 after accepting A (sll 2) with start held: A done in 3,
        // IDLE in 4, B (srl 1) accepted at the end of 4, done in 6.
        exp_done_b2b = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
        exp_busy_b2b = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1, 32'd1};

        bus.start       = 1'b0;
        bus.instruction = 32'h0;
        bus.rt_data     = 32'h0;
        bus.rs_data     = 32'h0;
        rst_n           = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset illegal", {31'd0, bus.illegal}, 32'd0);
        check("reset result", bus.result, 32'h0);
        step();
        step();
        #2 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i], i);
        end

        run_illegal(32'h0000_0020, "add");
        run_illegal(32'h0400_0000, "opcode1");

        // Start held high across two legal operations; operands change mid-shift.
        bus.instruction = 32'h0000_0080;  // sll 2
        bus.rt_data     = 32'h0000_0001;
        bus.rs_data     = 32'h0;
        bus.start       = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("b2b done c%0d", c), {31'd0, bus.done}, exp_done_b2b[c-1]);
            check($sformatf("b2b busy c%0d", c), {31'd0, bus.busy}, exp_busy_b2b[c-1]);
            check($sformatf("b2b illegal c%0d", c), {31'd0, bus.illegal}, 32'd0);
            if (c == 3 || c == 4) check($sformatf("b2b resultA c%0d", c), bus.result, 32'h0000_0004);
            if (c == 6) check("b2b resultB", bus.result, 32'h0000_0040);
            if (c == 1) begin
                bus.instruction = 32'h0000_0020;  // refused form while busy
                bus.rt_data     = 32'hFFFF_FFFF;
            end else begin
                bus.instruction = 32'h0000_0042;  // srl 1
                bus.rt_data     = 32'h0000_0080;
            end
            if (c == 6) bus.start = 1'b0;
            step();
        end
        check("b2b idle busy", {31'd0, bus.busy}, 32'd0);
        check("b2b idle result", bus.result, 32'h0000_0040);

        // Reset in the middle of a 20-bit shift, after 7 steps.
        bus.instruction = 32'h0000_0500;  // sll 20
        bus.rt_data     = 32'h0000_0001;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) step();
        check("mid result before reset", bus.result, 32'h0000_0080);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'd0, bus.busy}, 32'd0);
        check("mid reset done", {31'd0, bus.done}, 32'd0);
        check("mid reset result", bus.result, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("held reset done c%0d", c), {31'd0, bus.done}, 32'd0);
        end
        #2 rst_n = 1'b1;
        run_op(vecs[0], 100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
